// File: rtl/shift_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : shift_arb_pkg                                           |
// | Desc   : Shared types for the shift/rotate arbiter: op encoding  |
// |          and the bit positions of the {rotate,right} op field.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package shift_arb_pkg;

    // Op field is {rotate, right}
    typedef enum logic [1:0] {
        OP_SL = 2'b00,
        OP_SR = 2'b01,
        OP_RL = 2'b10,
        OP_RR = 2'b11
    } shift_op_t;

    localparam int c_OP_BIT_RIGHT = 0;
    localparam int c_OP_BIT_ROT   = 1;

endpackage
`default_nettype wire

// File: rtl/shift_arb_shift_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : shift_arb_shift_unit                                    |
// | Desc   : Combinational shift/rotate datapath. Logical shifts by  |
// |          DATA or more return zero; rotates use shamt mod DATA.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module shift_arb_shift_unit
    import shift_arb_pkg::*;
#(
    parameter int DATA  = 8,
    parameter int SHAMT = 3
) (
    input  logic [DATA-1:0]  data,
    input  logic [SHAMT-1:0] shamt,
    input  shift_op_t        op,
    output logic [DATA-1:0]  result
);

    localparam int c_AW = $clog2(DATA);

    logic [c_AW-1:0]   w_rot_amt;
    logic [c_AW-1:0]   w_amt;
    logic [2*DATA-1:0] w_dbl;
    logic [DATA-1:0]   w_rot;
    logic              w_oversize;

    // Rotate amount is shamt mod DATA; DATA is a power of two so this is a
    // truncation (or zero-extension when shamt is narrower).
    generate
        if (SHAMT >= c_AW) begin : g_rot_trunc
            assign w_rot_amt = shamt[c_AW-1:0];
        end else begin : g_rot_ext
            assign w_rot_amt = {{(c_AW-SHAMT){1'b0}}, shamt};
        end
    endgenerate

    assign w_oversize = (32'(shamt) >= 32'(DATA));

    // A left rotate by r is a right rotate by (-r mod DATA); both are taken
    // from the low half of the doubled operand, so a zero amount returns data
    // without ever forming a DATA-wide shift.
    assign w_amt = op[c_OP_BIT_RIGHT] ? w_rot_amt : (c_AW'(0) - w_rot_amt);
    assign w_dbl = {data, data};
    assign w_rot = DATA'(w_dbl >> w_amt);

    // Select the result for the requested op
    always_comb begin
        result = '0;
        case (op)
            OP_SL:   result = w_oversize ? '0 : (data << shamt);
            OP_SR:   result = w_oversize ? '0 : (data >> shamt);
            OP_RL,
            OP_RR:   result = op[c_OP_BIT_ROT] ? w_rot : '0;
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : shift_arb                                               |
// | Desc   : Round-robin arbiter sharing one shift/rotate unit among |
// |          REQ requesters; responses are tagged with requester id. |
// |          Define SHIFT_ARB_PIPE_EN for a two-stage (latency 2)    |
// |          build; default is a single output register (latency 1).|
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module shift_arb
    import shift_arb_pkg::*;
#(
    parameter int  REQ   = 4,
    parameter int  DATA  = 8,
    parameter int  SHAMT = 3,
    localparam int IDW   = $clog2(REQ)
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [REQ-1:0]        req_valid,
    output logic [REQ-1:0]        req_ready,
    input  logic [REQ*DATA-1:0]   req_data,
    input  logic [REQ*SHAMT-1:0]  req_shamt,
    input  logic [REQ*2-1:0]      req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [DATA-1:0]       resp_data
);

    logic [IDW-1:0]   r_ptr;
    logic [REQ-1:0]   w_mask;
    logic [REQ-1:0]   w_hi;
    logic [REQ-1:0]   w_pick;
    logic [REQ-1:0]   w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_free;
    logic             w_xfer;

    logic [DATA-1:0]  w_sel_data;
    logic [SHAMT-1:0] w_sel_shamt;
    shift_op_t        w_sel_op;

    logic [DATA-1:0]  w_su_data;
    logic [SHAMT-1:0] w_su_shamt;
    shift_op_t        w_su_op;
    logic [DATA-1:0]  w_result;

    logic             r_resp_valid;
    logic [IDW-1:0]   r_resp_id;
    logic [DATA-1:0]  r_resp_data;

    // Mask keeps requesters at or above the round-robin pointer
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < REQ; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
        end
    end

    // Search the masked set first; fall back to the full set to wrap around
    assign w_hi    = req_valid & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : req_valid;
    assign w_grant = w_pick & (~w_pick + REQ'(1));

    // Encode the one-hot grant into an index
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = IDW'(i);
            end
        end
    end

    assign req_ready = w_grant & {REQ{w_free}};
    assign w_xfer    = |req_ready;

    assign w_sel_data  = req_data[w_gidx*DATA +: DATA];
    assign w_sel_shamt = req_shamt[w_gidx*SHAMT +: SHAMT];
    assign w_sel_op    = shift_op_t'(req_op[w_gidx*2 +: 2]);

    // Pointer moves past the granted requester only on a transfer
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gidx == IDW'(REQ-1)) ? '0 : (w_gidx + IDW'(1));
        end
    end

`ifdef SHIFT_ARB_PIPE_EN
    logic             r_s1_valid;
    logic [IDW-1:0]   r_s1_id;
    logic [DATA-1:0]  r_s1_data;
    logic [SHAMT-1:0] r_s1_shamt;
    shift_op_t        r_s1_op;
    logic             w_s2_free;

    // Stage 1 advances whenever stage 2 is empty or draining
    assign w_s2_free  = !r_resp_valid || resp_ready;
    assign w_free     = !r_s1_valid || w_s2_free;

    assign w_su_data  = r_s1_data;
    assign w_su_shamt = r_s1_shamt;
    assign w_su_op    = r_s1_op;

    // Stage 1 captures the granted operand
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_data  <= '0;
            r_s1_shamt <= '0;
            r_s1_op    <= OP_SL;
        end else if (w_free) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_id    <= w_gidx;
                r_s1_data  <= w_sel_data;
                r_s1_shamt <= w_sel_shamt;
                r_s1_op    <= w_sel_op;
            end
        end
    end

    // Stage 2 registers the shift result for the response port
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else if (w_s2_free) begin
            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_resp_id   <= r_s1_id;
                r_resp_data <= w_result;
            end
        end
    end
`else
    assign w_free     = !r_resp_valid || resp_ready;

    assign w_su_data  = w_sel_data;
    assign w_su_shamt = w_sel_shamt;
    assign w_su_op    = w_sel_op;

    // Single output register: load on transfer, clear once consumed
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else if (w_xfer) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_gidx;
            r_resp_data  <= w_result;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end
`endif

    shift_arb_shift_unit #(
        .DATA  (DATA),
        .SHAMT (SHAMT)
    ) u_shift_unit (
        .data   (w_su_data),
        .shamt  (w_su_shamt),
        .op     (w_su_op),
        .result (w_result)
    );

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_shift_arb                                            |
// | Desc   : Self-checking bench for shift_arb: op vector table,     |
// |          directed reset/round-robin/backpressure/sparse cases    |
// |          and randomized traffic against a transaction model.     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_shift_arb;
    import shift_arb_pkg::*;

`ifdef SHIFT_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset_;

    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic [11:0] req_shamt;
    logic [7:0]  req_op;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;

    logic [3:0]  d4_req_valid, d4_req_ready;
    logic [31:0] d4_req_data;
    logic [15:0] d4_req_shamt;
    logic [7:0]  d4_req_op;
    logic        d4_resp_valid, d4_resp_ready;
    logic [1:0]  d4_resp_id;
    logic [7:0]  d4_resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          sel4;
        shift_op_t   op;
        logic [7:0]  d;
        logic [3:0]  s;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[16];

    shift_arb #(.REQ(4), .DATA(8), .SHAMT(3)) u_dut (
        .clk        (clk),
        .reset_     (reset_),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    shift_arb #(.REQ(4), .DATA(8), .SHAMT(4)) u_dut4 (
        .clk        (clk),
        .reset_     (reset_),
        .req_valid  (d4_req_valid),
        .req_ready  (d4_req_ready),
        .req_data   (d4_req_data),
        .req_shamt  (d4_req_shamt),
        .req_op     (d4_req_op),
        .resp_valid (d4_resp_valid),
        .resp_ready (d4_resp_ready),
        .resp_id    (d4_resp_id),
        .resp_data  (d4_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the op definitions
    function automatic logic [7:0] ref_shift(input logic [1:0] op, input logic [7:0] d, input int s);
        int v;
        int r;
        v = int'(d);
        r = s % 8;
        case (op)
            2'b00:   return (s >= 8) ? 8'h00 : 8'((v << s) & 255);
            2'b01:   return (s >= 8) ? 8'h00 : 8'(v >> s);
            2'b10:   return (r == 0) ? d : 8'(((v << r) | (v >> (8 - r))) & 255);
            default: return (r == 0) ? d : 8'(((v >> r) | (v << (8 - r))) & 255);
        endcase
    endfunction

    task automatic idle_all();
        req_valid     = '0;
        d4_req_valid  = '0;
        resp_ready    = 1'b1;
        d4_resp_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        idle_all();
        @(negedge clk);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'h11 * (i + 1));
        req_shamt = '0;
        req_op    = '0;
    endtask

    task automatic send_one(input int idx);
        vec_t v;
        int   j;
        v = vecs[idx];
        j = idx % 4;
        @(negedge clk);
        idle_all();
        if (v.sel4) begin
            d4_req_valid           = 4'(1 << j);
            d4_req_data[j*8 +: 8]  = v.d;
            d4_req_shamt[j*4 +: 4] = v.s;
            d4_req_op[j*2 +: 2]    = v.op;
        end else begin
            req_valid              = 4'(1 << j);
            req_data[j*8 +: 8]     = v.d;
            req_shamt[j*3 +: 3]    = v.s[2:0];
            req_op[j*2 +: 2]       = v.op;
        end
        @(negedge clk);
        req_valid    = '0;
        d4_req_valid = '0;
        repeat (LAT - 1) @(negedge clk);
        if (v.sel4) begin
            check($sformatf("vec%0d_valid", idx), d4_resp_valid, 1);
            check($sformatf("vec%0d_id", idx),    d4_resp_id, j);
            check($sformatf("vec%0d_data", idx),  d4_resp_data, v.exp);
        end else begin
            check($sformatf("vec%0d_valid", idx), resp_valid, 1);
            check($sformatf("vec%0d_id", idx),    resp_id, j);
            check($sformatf("vec%0d_data", idx),  resp_data, v.exp);
        end
    endtask

    initial begin
        bit         m_v[2];
        int         m_id[2];
        logic [7:0] m_d[2];
        bit         fr[2];
        int         m_ptr;
        int         g;
        logic [3:0] exp_rdy;

        vecs[0]  = '{1'b0, OP_SL, 8'h96, 4'd3, 8'hB0};
        vecs[1]  = '{1'b0, OP_SR, 8'h96, 4'd3, 8'h12};
        vecs[2]  = '{1'b0, OP_RL, 8'h96, 4'd3, 8'hB4};
        vecs[3]  = '{1'b0, OP_RR, 8'h96, 4'd3, 8'hD2};
        vecs[4]  = '{1'b0, OP_RL, 8'h96, 4'd0, 8'h96};
        vecs[5]  = '{1'b0, OP_RR, 8'h96, 4'd0, 8'h96};
        vecs[6]  = '{1'b0, OP_SL, 8'hFF, 4'd7, 8'h80};
        vecs[7]  = '{1'b0, OP_SR, 8'hFF, 4'd7, 8'h01};
        vecs[8]  = '{1'b0, OP_RR, 8'h96, 4'd7, 8'h2D};
        vecs[9]  = '{1'b1, OP_SL, 8'h96, 4'd9, 8'h00};
        vecs[10] = '{1'b1, OP_SR, 8'h96, 4'd9, 8'h00};
        vecs[11] = '{1'b1, OP_RL, 8'h96, 4'd9, 8'h2D};
        vecs[12] = '{1'b1, OP_RR, 8'h96, 4'd9, 8'h4B};
        vecs[13] = '{1'b1, OP_SL, 8'hFF, 4'd8, 8'h00};
        vecs[14] = '{1'b1, OP_RL, 8'h96, 4'd8, 8'h96};
        vecs[15] = '{1'b1, OP_SR, 8'hFF, 4'd4, 8'h0F};

        reset_       = 1'b0;
        req_data     = '0;
        req_shamt    = '0;
        req_op       = '0;
        d4_req_data  = '0;
        d4_req_shamt = '0;
        d4_req_op    = '0;
        idle_all();

        // Reset values
        @(negedge clk);
        #1;
        check("reset_valid", resp_valid, 0);
        check("reset_id",    resp_id, 0);
        check("reset_data",  resp_data, 0);
        @(negedge clk);
        reset_ = 1'b1;

        // Mid-stream asynchronous reset discards the held response
        @(negedge clk);
        load_ramp();
        req_valid  = 4'hF;
        resp_ready = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        check("pre_rst_valid", resp_valid, 1);
        #2;
        reset_ = 1'b0;
        #1;
        check("async_rst_valid", resp_valid, 0);
        check("async_rst_id",    resp_id, 0);
        check("async_rst_data",  resp_data, 0);
        @(negedge clk);
        reset_     = 1'b1;
        resp_ready = 1'b1;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        repeat (LAT) @(negedge clk);
        check("post_rst_valid", resp_valid, 1);
        check("post_rst_id",    resp_id, 0);

        // Op vector table
        for (int i = 0; i < 16; i++) send_one(i);

        // Full-load round robin
        do_reset();
        @(negedge clk);
        load_ramp();
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        for (int k = 1; k <= 8 + LAT - 1; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                check("rr_valid", resp_valid, 1);
                check("rr_id",    resp_id, (k - LAT) % 4);
                check("rr_data",  resp_data, 8'h11 * ((k - LAT) % 4 + 1));
            end
        end

        // Backpressure: response holds, no requests accepted
        do_reset();
        @(negedge clk);
        load_ramp();
        req_valid  = 4'hF;
        resp_ready = 1'b0;
        for (int k = 0; k < LAT; k++) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", resp_valid, 1);
            check("bp_id",    resp_id, 0);
            check("bp_data",  resp_data, 8'h11);
            check("bp_ready", req_ready, 4'b0000);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'(1 << LAT));
        @(posedge clk);
        #1;
        check("bp_next_valid", resp_valid, 1);
        check("bp_next_id",    resp_id, 1);
        check("bp_next_data",  resp_data, 8'h22);

        // Sparse requesters with wrap, then an idle cycle
        do_reset();
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        @(negedge clk);
        req_valid  = 4'b1010;
        #1;
        check("sparse_1st", req_ready, 4'b1000);
        @(negedge clk);
        #1;
        check("sparse_2nd", req_ready, 4'b0010);
        @(negedge clk);
        #1;
        check("sparse_3rd", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        check("idle_ptr_hold", req_ready, 4'b0001);

        // Randomized traffic against the transaction model
        do_reset();
        m_ptr = 0;
        m_v   = '{1'b0, 1'b0};
        m_id  = '{0, 0};
        m_d   = '{8'h00, 8'h00};
        fr    = '{1'b0, 1'b0};
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid  = 4'($urandom);
            req_data   = $urandom;
            req_shamt  = 12'($urandom);
            req_op     = 8'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            fr[LAT-1] = !m_v[LAT-1] || resp_ready;
            if (LAT == 2) fr[0] = !m_v[0] || fr[1];
            exp_rdy = (fr[0] && g >= 0) ? 4'(1 << g) : 4'b0000;
            check("rand_ready", req_ready, exp_rdy);
            @(posedge clk);
            if (LAT == 2 && fr[1]) begin
                m_v[1]  = m_v[0];
                m_id[1] = m_id[0];
                m_d[1]  = m_d[0];
            end
            if (fr[0]) begin
                m_v[0] = (g >= 0);
                if (g >= 0) begin
                    m_id[0] = g;
                    m_d[0]  = ref_shift(req_op[g*2 +: 2], req_data[g*8 +: 8], int'(req_shamt[g*3 +: 3]));
                    m_ptr   = (g + 1) % 4;
                end
            end
            #1;
            check("rand_valid", resp_valid, m_v[LAT-1]);
            if (m_v[LAT-1]) begin
                check("rand_id",   resp_id, m_id[LAT-1]);
                check("rand_data", resp_data, m_d[LAT-1]);
            end
        end

        @(negedge clk);
        idle_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
